// File: rtl/mod_sub_arbiter.sv
// Round-robin arbiter sharing one secp256k1 modular subtractor among NUM_REQ
// requesters, with registered operands/result and valid/ready on both sides.

module mod_sub (
  input  logic [255:0] x,
  input  logic [255:0] y,
  output logic [255:0] difference
);
  localparam logic [255:0] P =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  logic [256:0] raw;

  // A borrow out of the 257-bit subtraction means x < y, so fold p back in.
  always_comb begin
    raw        = {1'b0, x} - {1'b0, y};
    difference = raw[256] ? (raw[255:0] + P) : raw[255:0];
  end
endmodule

module mod_sub_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [256*NUM_REQ-1:0] req_x,
  input  logic [256*NUM_REQ-1:0] req_y,
  output logic                   rsp_valid,
  output logic [ID_W-1:0]        rsp_id,
  output logic [255:0]           rsp_diff,
  input  logic                   rsp_ready,
  output logic                   busy
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [255:0]    op_x_q, op_x_d;
  logic [255:0]    op_y_q, op_y_d;
  logic [255:0]    rsp_diff_q, rsp_diff_d;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_id;
  logic [255:0]    diff;

  mod_sub u_mod_sub (
    .x          (op_x_q),
    .y          (op_y_q),
    .difference (diff)
  );

  // Circular search starting at rr_ptr_q; the first valid requester wins.
  always_comb begin : grant_search
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_x_d     = op_x_q;
    op_y_d     = op_y_q;
    op_id_d    = op_id_q;
    rsp_diff_d = rsp_diff_q;
    rsp_id_d   = rsp_id_q;
    req_ready  = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          // Gated so a grant never shows while reset holds the block idle.
          req_ready[gnt_id] = reset;
          op_x_d   = req_x[int'(gnt_id)*256 +: 256];
          op_y_d   = req_y[int'(gnt_id)*256 +: 256];
          op_id_d  = gnt_id;
          rr_ptr_d = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_W'(1);
          state_d  = CALC;
        end
      end
      CALC: begin
        rsp_diff_d = diff;
        rsp_id_d   = op_id_q;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the wide operand/result registers are reset too, because a reset
  // must visibly clear rsp_diff/rsp_id and discard any in-flight operands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      op_x_q     <= '0;
      op_y_q     <= '0;
      op_id_q    <= '0;
      rsp_diff_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_x_q     <= op_x_d;
      op_y_q     <= op_y_d;
      op_id_q    <= op_id_d;
      rsp_diff_q <= rsp_diff_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_diff  = rsp_diff_q;
  assign rsp_id    = rsp_id_q;
endmodule
